// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared types and constants for the shift-add multiplier control
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

    // Default operand width, which is also the iteration count.
    localparam int MULT_N = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_sequencer_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : edge_detect
//  Purpose  : Rising-edge detector. Keeps the previous sample in a register,
//             so a level held high yields a single-cycle pulse.
//  Revision : 1.0  initial release
// ============================================================================
module edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic in,
    output logic rise
);

    logic r_prev;

    // Register the previous input sample; cleared by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= in;
        end
    end

    assign rise = in & ~r_prev;

endmodule : edge_detect
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mult_sequencer
//  Purpose  : Control FSM for an N-bit shift-add signed multiplier. Each Run
//             press clears X:A, then runs N add/sub + shift iterations; the
//             final iteration subtracts (two's-complement multiplier).
//             Operand load is accepted only while idle.
//  Revision : 1.0  initial release
// ============================================================================
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic ClearXA,
    output logic LoadB,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_run_rise;

    // One-cycle pulse on each fresh Run press.
    edge_detect u_run_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .in    (Run),
        .rise  (w_run_rise)
    );

    // State and iteration counter; reset aborts any multiply in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and output decode. Add/Sub follow M combinationally so the
    // datapath sees the current multiplier bit in the ADD cycle itself.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        ClearXA    = 1'b0;
        LoadB      = 1'b0;
        Add        = 1'b0;
        Sub        = 1'b0;
        Shift      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_run_rise) begin
                    // A press takes priority over a simultaneous load request.
                    w_next = CLEAR;
                end else if (ClearA_LoadB) begin
                    LoadB   = 1'b1;
                    ClearXA = 1'b1;
                end
            end
            CLEAR: begin
                ClearXA    = 1'b1;
                Busy       = 1'b1;
                w_cnt_next = '0;
                w_next     = ADD;
            end
            ADD: begin
                Busy   = 1'b1;
                // The multiplier MSB carries negative weight, so the last
                // partial product is subtracted.
                if (r_cnt == LAST) begin
                    Sub = M;
                end else begin
                    Add = M;
                end
                w_next = SHIFT;
            end
            SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = HOLD;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    w_next     = ADD;
                end
            end
            HOLD: begin
                // Held until Run is released, preventing an auto-restart.
                Done = 1'b1;
                if (!Run) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule : mult_sequencer
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_sequencer
//  Purpose  : Directed self-checking bench for mult_sequencer (N = 8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_sequencer;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic ClearXA, LoadB, Add, Sub, Shift, Busy, Done;
    logic [6:0] outs;

    int n_cmp = 0;
    int n_bad = 0;
    int n_add, n_sub, n_shift;

    always #5 Clk = ~Clk;

    mult_sequencer #(.N(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .ClearXA      (ClearXA),
        .LoadB        (LoadB),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done)
    );

    // Output bundle: {ClearXA, LoadB, Add, Sub, Shift, Busy, Done}
    assign outs = {ClearXA, LoadB, Add, Sub, Shift, Busy, Done};

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One multiply: press in cycle 0, check cycles 1..18.
    // b_init feeds M through a shifting model of B; mask is the hand-derived
    // set of iterations expected to add/subtract. release_at drops Run in
    // that cycle; reset_at pulses Reset in that cycle and ends the run early.
    task automatic run_mult(input string tag, input logic [7:0] b_init,
                            input logic [7:0] mask, input logic clb,
                            input int release_at, input int reset_at);
        logic [7:0] b;
        logic [6:0] exp;
        int k;
        b = b_init;
        Run = 1'b1;
        ClearA_LoadB = clb;
        M = b[0];
        #1;
        check({tag, "_press"}, outs, 7'b0000000);
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c >= 4 && (c % 2) == 0) b = {b[7], b[7:1]};
            M = b[0];
            if (c == release_at) Run = 1'b0;
            if (c == reset_at) begin
                Reset = 1'b1;
                Run   = 1'b0;
            end
            #1;
            k = (c - 2) / 2;
            exp = 7'b0;
            exp[6] = (c == 1);
            exp[4] = (c >= 2) && (c <= 14) && (c % 2 == 0) && mask[k];
            exp[3] = (c == 16) && mask[7];
            exp[2] = (c >= 3) && (c <= 17) && (c % 2 == 1);
            exp[1] = (c >= 1) && (c <= 17);
            exp[0] = (c == 18);
            check($sformatf("%s_c%0d", tag, c), outs, exp);
            if (Add)   n_add++;
            if (Sub)   n_sub++;
            if (Shift) n_shift++;
            if (c == reset_at) begin
                tick();
                Reset = 1'b0;
                #1;
                check({tag, "_after_reset"}, outs, 7'b0000000);
                return;
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        n_add = 0; n_sub = 0; n_shift = 0;

        // Reset held two cycles, then idle with everything low.
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        #1 check("reset_idle", outs, 7'b0000000);
        tick();
        check("idle_quiet", outs, 7'b0000000);

        // M held high: Add at 2..14, Sub at 16, Shift at odd cycles, Done at 18.
        run_mult("m1", 8'hFF, 8'hFF, 1'b0, 0, 0);

        // Run still high: Done held, no restart.
        for (int i = 19; i <= 30; i++) begin
            tick();
            check($sformatf("hold_c%0d", i), outs, 7'b0000001);
        end
        tick();
        Run = 1'b0;
        #1 check("hold_release", outs, 7'b0000001);
        tick();
        check("back_idle", outs, 7'b0000000);

        // B = 0xAA shifting: adds at iterations 1,3,5, subtract at 7.
        n_add = 0; n_sub = 0; n_shift = 0;
        tick();
        run_mult("bAA", 8'hAA, 8'b1010_1010, 1'b0, 0, 0);
        check_int("aa_adds", n_add, 3);
        check_int("aa_subs", n_sub, 1);
        check_int("aa_shifts", n_shift, 8);
        tick();
        Run = 1'b0;
        #1 check("aa_release", outs, 7'b0000001);
        tick();
        check("aa_idle", outs, 7'b0000000);

        // Load request in IDLE is honoured combinationally.
        ClearA_LoadB = 1'b1;
        #1 check("load_idle", outs, 7'b1100000);
        tick();
        check("load_idle2", outs, 7'b1100000);

        // Load request held through a multiply (M=0) is ignored; Run dropped
        // mid-multiply; HOLD exits right after Done.
        run_mult("ld", 8'h00, 8'h00, 1'b1, 5, 0);
        tick();
        check("ld_exit_idle_load", outs, 7'b1100000);
        ClearA_LoadB = 1'b0;
        #1 check("ld_exit_idle", outs, 7'b0000000);
        tick();

        // Reset in the middle of iteration 3 aborts to IDLE.
        run_mult("rst", 8'hFF, 8'hFF, 1'b0, 0, 8);
        tick();
        check("rst_idle", outs, 7'b0000000);

        // Fresh press after the abort gives the complete sequence.
        run_mult("again", 8'hFF, 8'hFF, 1'b0, 0, 0);
        tick();
        Run = 1'b0;
        #1 check("again_release", outs, 7'b0000001);
        tick();
        check("again_idle", outs, 7'b0000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mult_sequencer
`default_nettype wire
